// File: rtl/alu_msb.sv
// alu_msb: most-significant-bit slice of a ripple-carry MIPS-style ALU.
// Computes AND / OR / ADD-SUB / LESS pass-through for bit N-1, along with
// the Set bit (adder sum, sign of A-B for SLT) and the word's signed
// Overflow flag. All three outputs are registered (one-cycle latency).
module alu_msb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       Ainvert,
    input  logic       Binvert,
    input  logic       CarryIn,
    input  logic [1:0] Operation,
    input  logic       Less,
    output logic       Result,
    output logic       Overflow,
    output logic       Set
);

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_ADD  = 2'd2,
        OP_LESS = 2'd3
    } alu_op_t;

    alu_op_t op;
    logic    aa;
    logic    bb;
    logic    sum;
    logic    cout;
    logic    result_next;
    logic    overflow_next;
    logic    set_next;

    assign op = alu_op_t'(Operation);

    // Effective operands, full adder and result selection for the MSB.
    always_comb begin
        aa            = a ^ Ainvert;
        bb            = b ^ Binvert;
        sum           = aa ^ bb ^ CarryIn;
        cout          = (aa & bb) | (aa & CarryIn) | (bb & CarryIn);
        // Carry-out is only consumed here: signed overflow of the whole word.
        overflow_next = CarryIn ^ cout;
        set_next      = sum;
        result_next   = 1'b0;
        unique case (op)
            OP_AND:  result_next = aa & bb;
            OP_OR:   result_next = aa | bb;
            OP_ADD:  result_next = sum;
            OP_LESS: result_next = Less;
            default: result_next = 1'b0;
        endcase
    end

    // Output registers: capture every rising edge, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result   <= 1'b0;
            Overflow <= 1'b0;
            Set      <= 1'b0;
        end else begin
            Result   <= result_next;
            Overflow <= overflow_next;
            Set      <= set_next;
        end
    end

endmodule

// File: tb/tb_alu_msb.sv
// Testbench for alu_msb: directed vector table, reset sequences, an
// exhaustive back-to-back sweep and randomized stimulus against a model.
module tb_alu_msb;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       Ainvert;
    logic       Binvert;
    logic       CarryIn;
    logic [1:0] Operation;
    logic       Less;
    logic       Result;
    logic       Overflow;
    logic       Set;

    int checks   = 0;
    int failures = 0;

    alu_msb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .Ainvert   (Ainvert),
        .Binvert   (Binvert),
        .CarryIn   (CarryIn),
        .Operation (Operation),
        .Less      (Less),
        .Result    (Result),
        .Overflow  (Overflow),
        .Set       (Set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       a;
        logic       b;
        logic       ainv;
        logic       binv;
        logic       cin;
        logic [1:0] op;
        logic       less;
        logic       exp_result;
        logic       exp_ovf;
        logic       exp_set;
    } vec_t;

    // Reference: 1-bit two's-complement add of the effective operands.
    // Overflow means both operands share a sign the sum does not.
    function automatic logic [2:0] model(input logic [7:0] v);
        int av, bv, cv, total, res;
        logic s, ovf;
        av    = int'(v[7] ^ v[5]);
        bv    = int'(v[6] ^ v[4]);
        cv    = int'(v[3]);
        total = av + bv + cv;
        s     = logic'(total % 2);
        ovf   = (av == bv) && (int'(s) != av);
        case (int'(v[2:1]))
            0:       res = av * bv;
            1:       res = (av + bv > 0) ? 1 : 0;
            2:       res = total % 2;
            default: res = int'(v[0]);
        endcase
        return {logic'(res), ovf, s};
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        {a, b, Ainvert, Binvert, CarryIn, Operation, Less} = v;
    endtask

    task automatic check_all(input string tag, input logic [2:0] exp);
        check({tag, ".Result"},   Result,   exp[2]);
        check({tag, ".Overflow"}, Overflow, exp[1]);
        check({tag, ".Set"},      Set,      exp[0]);
    endtask

    vec_t vecs[$];

    initial begin
        logic [7:0] prev;
        logic [7:0] v;

        vecs.push_back('{"and_01",   0,1,0,0,1,2'd0,0, 0,0,0});
        vecs.push_back('{"or_01",    0,1,0,0,1,2'd1,0, 1,0,0});
        vecs.push_back('{"add_01",   0,1,0,0,1,2'd2,0, 0,0,0});
        vecs.push_back('{"sub_01",   0,1,0,1,1,2'd2,0, 1,1,1});
        vecs.push_back('{"slt_01",   0,1,0,1,1,2'd3,0, 0,1,1});
        vecs.push_back('{"and_11",   1,1,0,0,1,2'd0,1, 1,0,1});
        vecs.push_back('{"or_11",    1,1,0,0,1,2'd1,1, 1,0,1});
        vecs.push_back('{"add_11",   1,1,0,0,1,2'd2,1, 1,0,1});
        vecs.push_back('{"sub_11",   1,1,0,1,1,2'd2,1, 0,0,0});
        vecs.push_back('{"slt_11",   1,1,0,1,1,2'd3,1, 1,0,0});
        vecs.push_back('{"nor_00",   0,0,1,1,0,2'd0,0, 1,1,0});

        // Reset: outputs held at zero regardless of clock and inputs.
        rst_n = 1'b0;
        drive({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0});
        repeat (2) @(negedge clk);
        check_all("reset_hold", 3'b000);

        // Release: first capture at first rising edge with rst_n high.
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release.Result", Result, 1'b1);
        check_all("release", model({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0}));

        // Directed table.
        foreach (vecs[i]) begin
            @(negedge clk);
            {a, b, Ainvert, Binvert, CarryIn, Operation, Less} =
                {vecs[i].a, vecs[i].b, vecs[i].ainv, vecs[i].binv,
                 vecs[i].cin, vecs[i].op, vecs[i].less};
            @(posedge clk);
            #1;
            check_all(vecs[i].name, {vecs[i].exp_result, vecs[i].exp_ovf, vecs[i].exp_set});
        end

        // Async assertion mid-cycle: outputs clear without a clock edge.
        @(negedge clk);
        drive(8'b1100_0010);
        @(posedge clk);
        #2;
        check("async_pre.Result", Result, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all("async_clear", 3'b000);
        // Input changes while held in reset must not leak out.
        drive(8'b1111_1111);
        @(posedge clk);
        #1;
        check_all("reset_edge", 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", model(8'b1111_1111));

        // Input changes between edges do not reach outputs until the edge.
        @(negedge clk);
        drive(8'b0000_0000);
        @(posedge clk);
        #1;
        drive(8'b1100_0010);
        #2;
        check_all("glitch_hold", model(8'b0000_0000));

        // Exhaustive sweep, new vector every cycle.
        @(negedge clk);
        prev = 8'd0;
        drive(prev);
        for (int unsigned i = 1; i < 257; i++) begin
            @(negedge clk);
            check_all($sformatf("sweep[%0d]", i - 1), model(prev));
            if (i < 256) begin
                prev = 8'(i);
                drive(prev);
            end
        end

        // Randomized back-to-back stimulus.
        prev = 8'($urandom);
        drive(prev);
        for (int unsigned i = 0; i < 300; i++) begin
            @(negedge clk);
            check_all($sformatf("rand[%0d]", i), model(prev));
            v = 8'($urandom);
            prev = v;
            drive(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_msb.md
# alu_msb

Most-significant-bit slice of the ripple-carry MIPS-style ALU. It computes AND, OR, ADD/SUB and the SLT pass-through for bit N-1. It also produces the `Set` bit that feeds `Less` of bit 0, and the signed `Overflow` flag for the whole word. Outputs are registered, so the slice sits in the ALU's single pipeline stage alongside the registered LSB/middle slices.

## Interface
- No parameters.
- `clk`        input  1  rising-edge clock
- `rst_n`      input  1  asynchronous active-low reset
- `a`          input  1  operand A bit (MSB)
- `b`          input  1  operand B bit (MSB)
- `Ainvert`    input  1  1: use ~a
- `Binvert`    input  1  1: use ~b (SUB/SLT)
- `CarryIn`    input  1  carry from bit N-2 (or 1 for SUB in 1-bit use)
- `Operation`  input  2  0 AND, 1 OR, 2 ADD, 3 LESS pass-through
- `Less`       input  1  value returned on Result when Operation=3
- `Result`     output 1  registered selected result
- `Overflow`   output 1  registered signed overflow of the MSB adder
- `Set`        output 1  registered adder sum bit (sign of A-B for SLT)
- One clock; reset is asynchronous and active-low.

## Operation
- Effective operands:
  - `aa = a ^ Ainvert`
  - `bb = b ^ Binvert`
- Full adder:
  - `sum = aa ^ bb ^ CarryIn`
  - `cout = aa&bb | aa&CarryIn | bb&CarryIn`
- Result mux:
  - 0: `aa & bb`
  - 1: `aa | bb`
  - 2: `sum`
  - 3: `Less`
- `Set = sum`, computed every cycle regardless of `Operation`.
- `Overflow = CarryIn ^ cout`, computed every cycle regardless of `Operation`. Downstream control qualifies it by opcode.
- No carry-out port: the MSB carry is consumed internally for overflow only.
- All inputs are treated as unsigned single bits. No X-propagation special handling is required.

## Timing
- Combinational next-state from the current inputs. `Result`, `Overflow` and `Set` are captured on every rising `clk` edge.
- Latency: 1 cycle. Outputs reflect the inputs sampled at the previous edge. No enable and no handshake: a new operation is accepted every cycle.
- Reset: while `rst_n`=0, `Result`=0, `Overflow`=0 and `Set`=0, asynchronously and immediately on assertion.
- Reset release: the first capture happens at the first rising edge with `rst_n`=1.
- Reset mid-operation: the in-flight result is discarded, with no residual state. The slice has no state beyond the three output flops.
- Input changes between edges have no effect on the outputs until the next edge.

## Test plan
Each case samples the outputs one edge after the input is applied.
- **Reset:** assert `rst_n`=0 with a=1, b=1, Operation=1 -> Result=0, Overflow=0, Set=0, independent of `clk`. Release, one edge -> Result=1.
- **Logic ops:** a=0, b=1, Ainv=0, Binv=0, Cin=1, Less=0.
  - Op=0 -> Result=0.
  - Op=1 -> Result=1.
  - Op=2 -> Result=0, Set=0, Overflow=0 (cout=1).
- **Subtract path:** same inputs with Binv=1.
  - Op=2 -> Result=1, Set=1, Overflow=1.
  - Op=3 -> Result=0 (Less), Set=1, Overflow=1.
- **Second vector:** a=1, b=1, Binv=0, Cin=1, Less=1.
  - Op=0 -> 1.
  - Op=1 -> 1.
  - Op=2 -> Result=1, Set=1, Overflow=0.
  - Binv=1, Op=2 -> Result=0, Set=0, Overflow=0.
  - Op=3 -> Result=1.
- **Exhaustive sweep:** all 2^8 input combinations, each checked against a reference model one cycle later, including back-to-back changes every cycle.
- **Ainvert:** a=0, b=0, Ainv=1, Binv=1, Op=0 -> Result=1 (NOR identity).
